// File: rtl/addsub_pipe.sv
// addsub_pipe: segmented pipelined adder/subtractor.
//
// The WIDTH-bit operands are split into SEGS segments of SW = WIDTH/SEGS bits.
// Stage 1 adds segment 0 with the carry seed. It also forms carry-less
// (SW+1)-bit partial sums for every other segment. Each later stage then
// resolves one more segment by adding in the carry from the segment below.
// The longest carry chain is therefore one SW-bit adder.
//
// Parameters:
//   WIDTH     operand/result width, multiple of SEGS
//   SEGS      segment count = pipeline depth (1..WIDTH)
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset, clears every pipeline register
//   en        pipeline enable, 0 holds every register
//   in_valid  operands valid this cycle
//   sub       0: x + y + cin, 1: x - y - cin (cin acts as borrow-in)
//   x, y      operands (two's complement for overflow)
//   cin       carry-in / borrow-in
//   sum       result, SEGS enabled edges after the operands were sampled
//   cout      carry out of the MSB (subtract: 1 = no borrow)
//   ovf       signed overflow
//   out_valid sum/cout/ovf hold a valid result
// Build option:
//   ADDSUB_SAT_EN  when defined, sum saturates on signed overflow
//                  (ovf and cout still report the raw condition)
module addsub_pipe #(
   parameter int WIDTH = 32,
   parameter int SEGS  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             in_valid,
   input  logic             sub,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             out_valid
);

   localparam int SW = WIDTH / SEGS;

   logic [WIDTH-1:0] w_yp;
   logic             w_c0;

   assign w_yp = sub ? ~y : y;
   assign w_c0 = cin ^ sub;

   // Values presented to the final register stage.
   logic [WIDTH-1:0] w_fsum;
   logic             w_fcout;
   logic             w_fxm;
   logic             w_fym;
   logic             w_fv;

   generate
      if (SEGS == 1) begin : g_single
         logic [WIDTH:0] w_full;

         assign w_full  = {1'b0, x} + {1'b0, w_yp} + {{WIDTH{1'b0}}, w_c0};
         assign w_fsum  = w_full[WIDTH-1:0];
         assign w_fcout = w_full[WIDTH];
         assign w_fxm   = x[WIDTH-1];
         assign w_fym   = w_yp[WIDTH-1];
         assign w_fv    = in_valid;
      end else begin : g_pipe
         localparam int NS  = SEGS - 1;
         localparam int PCW = (SEGS * (SEGS - 1)) / 2;

         // Register stage i (0..NS-1) holds:
         //   segments 0..i resolved in r_lo, plus the carry out of segment i in r_c;
         //   segments i+1..SEGS-1 as partials (low bits in r_lo, carry bits in r_pc).
         // r_pc is packed as a triangle: stage i owns SEGS-1-i bits at pc_off(i),
         // so every stored partial-carry bit is consumed by the next stage.
         logic [WIDTH-1:0] r_lo   [NS];
         logic [WIDTH-1:0] w_lo_n [NS];
         logic [NS-1:0]    r_c;
         logic [NS-1:0]    w_c_n;
         logic [NS-1:0]    r_xm;
         logic [NS-1:0]    w_xm_n;
         logic [NS-1:0]    r_ym;
         logic [NS-1:0]    w_ym_n;
         logic [NS-1:0]    r_v;
         logic [NS-1:0]    w_v_n;
         logic [PCW-1:0]   r_pc;
         logic [PCW-1:0]   w_pc_n;
         logic [SW:0]      w_fa;

         function automatic int unsigned pc_off(input int unsigned i);
            return (i * (SEGS - 1)) - ((i * (i - 1)) / 2);
         endfunction

         always_comb begin
            logic [SW:0] w_t;
            w_t    = '0;
            w_c_n  = '0;
            w_pc_n = '0;
            for (int unsigned i = 0; i < NS; i++) begin
               w_lo_n[i] = '0;
            end

            // Stage 1: segment 0 absorbs the seed; the others add carry-less.
            w_t = {1'b0, x[SW-1:0]} + {1'b0, w_yp[SW-1:0]} + {{SW{1'b0}}, w_c0};
            w_lo_n[0][SW-1:0] = w_t[SW-1:0];
            w_c_n[0]          = w_t[SW];
            for (int unsigned j = 1; j < SEGS; j++) begin
               w_t = {1'b0, x[j*SW +: SW]} + {1'b0, w_yp[j*SW +: SW]};
               w_lo_n[0][j*SW +: SW] = w_t[SW-1:0];
               w_pc_n[j-1]           = w_t[SW];
            end

            // Stages 2..SEGS-1: resolve segment i with the carry from segment i-1.
            // A partial never exceeds 2^(SW+1)-2, so at most one of its carry bit
            // and the add carry can be set and OR-ing them gives the segment carry.
            for (int unsigned i = 1; i < NS; i++) begin
               w_t = {1'b0, r_lo[i-1][i*SW +: SW]} + {{SW{1'b0}}, r_c[i-1]};
               w_lo_n[i]             = r_lo[i-1];
               w_lo_n[i][i*SW +: SW] = w_t[SW-1:0];
               w_c_n[i]              = r_pc[pc_off(i-1)] | w_t[SW];
               for (int unsigned j = i + 1; j < SEGS; j++) begin
                  w_pc_n[pc_off(i) + j - i - 1] = r_pc[pc_off(i-1) + j - i];
               end
            end

            w_xm_n[0] = x[WIDTH-1];
            w_ym_n[0] = w_yp[WIDTH-1];
            w_v_n[0]  = in_valid;
            for (int unsigned i = 1; i < NS; i++) begin
               w_xm_n[i] = r_xm[i-1];
               w_ym_n[i] = r_ym[i-1];
               w_v_n[i]  = r_v[i-1];
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int unsigned i = 0; i < NS; i++) begin
                  r_lo[i] <= '0;
               end
               r_c  <= '0;
               r_pc <= '0;
               r_xm <= '0;
               r_ym <= '0;
               r_v  <= '0;
            end else if (en) begin
               for (int unsigned i = 0; i < NS; i++) begin
                  r_lo[i] <= w_lo_n[i];
               end
               r_c  <= w_c_n;
               r_pc <= w_pc_n;
               r_xm <= w_xm_n;
               r_ym <= w_ym_n;
               r_v  <= w_v_n;
            end
         end

         // Final stage resolves the top segment.
         assign w_fa = {1'b0, r_lo[NS-1][NS*SW +: SW]} + {{SW{1'b0}}, r_c[NS-1]};

         always_comb begin
            w_fsum                = r_lo[NS-1];
            w_fsum[NS*SW +: SW]   = w_fa[SW-1:0];
         end

         assign w_fcout = r_pc[PCW-1] | w_fa[SW];
         assign w_fxm   = r_xm[NS-1];
         assign w_fym   = r_ym[NS-1];
         assign w_fv    = r_v[NS-1];
      end
   endgenerate

   logic             w_ovf;
   logic [WIDTH-1:0] w_res;

   assign w_ovf = (w_fxm == w_fym) && (w_fsum[WIDTH-1] != w_fxm);

`ifdef ADDSUB_SAT_EN
   // On overflow both operands share a sign, so x's sign gives the direction.
   always_comb begin
      w_res = w_fsum;
      if (w_ovf) begin
         w_res = w_fxm ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end
`else
   assign w_res = w_fsum;
`endif

   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;
   logic             r_ov;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum  <= '0;
         r_cout <= 1'b0;
         r_ovf  <= 1'b0;
         r_ov   <= 1'b0;
      end else if (en) begin
         r_sum  <= w_res;
         r_cout <= w_fcout;
         r_ovf  <= w_ovf;
         r_ov   <= w_fv;
      end
   end

   assign sum       = r_sum;
   assign cout      = r_cout;
   assign ovf       = r_ovf;
   assign out_valid = r_ov;

endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Parametrised, segmented pipelined adder/subtractor: WIDTH-bit operands are split into SEGS equal segments, and one segment carry is resolved per pipeline stage, so the critical path is one WIDTH/SEGS-bit adder. It is the general-width, N-stage successor of the fixed three-segment pipelined adder. It adds add/subtract mode, carry/borrow-in, signed overflow, a valid pipeline and a global stall. It sits in datapaths (accumulators, FIR/CIC integrators) where the full-width carry chain cannot close timing.

## Interface
- WIDTH, 32: operand and result width; must be a multiple of SEGS.
- SEGS, 4: number of segments and pipeline stages, 1..WIDTH; segment width SW = WIDTH/SEGS.
- clk  in  1  system clock; all registers on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  pipeline enable; 0 = stall, all registers hold.
- in_valid  in  1  operands valid this cycle.
- sub  in  1  0 = x + y + cin; 1 = x - y - cin (cin acts as borrow-in).
- x, y  in  WIDTH  operands (two's complement for ovf purposes).
- cin  in  1  carry-in / borrow-in.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB (for sub: 1 = no borrow).
- ovf  out  1  signed overflow of the result.
- out_valid  out  1  sum/cout/ovf carry a valid result.

## Operation
- Internal operand: y' = sub ? ~y : y; carry seed c0 = cin ^ sub.
- Stage 1 captures x, y', c0 and in_valid.
  - Adds segment 0 with c0, keeping SW result bits and the segment carry.
  - Adds every other segment pair without carry into SW+1-bit partial sums.
- Stage k (2..SEGS) adds the carry from segment k-2 into partial segment k-1.
  - Resolved lower segments and pending upper partials shift forward unchanged.
  - A segment never absorbs more than one carry; the (SW+1)-bit partial plus 1 cannot overflow SW+2 bits. The carry out of segment k-1 is the OR of the partial's carry bit and the add carry.
- Final stage registers:
  - sum = concatenation of resolved segments.
  - cout = carry out of the top segment.
  - ovf = (x[MSB] == y'[MSB]) && (sum[MSB] != x[MSB]). The operand MSBs are carried down the pipe.
- SEGS = 1 degenerates to a single registered full-width adder.
- Data registers load whenever en=1, regardless of in_valid. Downstream qualifies on out_valid only.
- Results emerge strictly in input order. No back-pressure beyond en.

## Timing
- Latency SEGS cycles: operands sampled at edge t with en=1 appear at edge t+SEGS-1 after SEGS enabled edges. Stalled cycles add one each.
- Throughput: one operation per enabled cycle.
- out_valid is in_valid delayed by SEGS enabled edges.
- en=0: every register, including out_valid, holds. Outputs are stable and out_valid is not re-asserted as a new result.
- Reset (rst_n low, any time, including mid-stream): all pipeline registers clear immediately, and in-flight operations are discarded.
  - Reset values: sum=0, cout=0, ovf=0, out_valid=0.
  - The first valid output after release comes SEGS enabled edges after the first accepted in_valid.
- sub, cin, x and y are sampled together at stage 1 only. Mode changes between back-to-back operations are legal.

## Configuration
- ADDSUB_SAT_EN defined: the final stage saturates on overflow.
  - Positive overflow gives sum = 0x7F..F; negative overflow gives 0x80..0.
  - ovf and cout still report the raw condition, and latency is unchanged.
- Undefined: sum is the wrapped modulo-2^WIDTH result, and no saturation logic is generated.

## Test plan
- WIDTH=32, SEGS=4, add x=0x00FFFFFF, y=0x00000001, cin=0: after exactly 4 cycles sum=0x01000000, cout=0, ovf=0, out_valid for one cycle.
- Add 0xFFFFFFFF + 0x00000001: sum=0x00000000, cout=1, ovf=0. Repeat with cin=1 and y=0: same result.
- sub=1, x=5, y=7, cin=0 gives sum=0xFFFFFFFE, cout=0. Then x=7, y=5, cin=1 gives sum=0x00000001, cout=1.
- Add 0x7FFFFFFF + 1: ovf=1; sum=0x80000000 without ADDSUB_SAT_EN, 0x7FFFFFFF with it. Sub 0x80000000 - 1: ovf=1; sum=0x7FFFFFFF wrapped, 0x80000000 saturated.
- Stream 16 random back-to-back operations with en toggled low for 3 cycles mid-stream:
  - every result matches a reference model, in order;
  - out_valid count equals accepted in_valid count;
  - outputs hold during the stall.
- Assert rst_n low for one cycle with 3 operations in flight: all outputs read 0 immediately, and no stale out_valid appears afterwards. Repeat the full set with SEGS=1 and SEGS=8 (WIDTH=32).
